// File: rtl/speech256_pkg.sv
// Shared constants and helpers for the Speech256 excitation source.
// Holds LFSR taps, default generics and the sample width.
package speech256_pkg;

    localparam int SAMPLE_W = 16;
    localparam int LFSR_W = 17;
    localparam int PERIOD_W = 8;

    localparam int LFSR_TAP_A = 16;
    localparam int LFSR_TAP_B = 13;

    localparam int NOISE_PERIOD_DEF = 64;
    localparam logic [LFSR_W-1:0] LFSR_SEED_DEF = 17'h00001;

    // One Fibonacci step of x^17 + x^14 + 1.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] cur);
        return {cur[LFSR_W-2:0], cur[LFSR_TAP_A] ^ cur[LFSR_TAP_B]};
    endfunction

    function automatic logic [SAMPLE_W-1:0] amp_to_mag(input logic [SAMPLE_W-1:0] amp);
        return {1'b0, amp[SAMPLE_W-1:1]};
    endfunction

endpackage

// File: rtl/speech_lfsr.sv
// 17-bit noise LFSR for the unvoiced excitation.
// Loads the seed on reset and advances one step per enabled clock.
module speech_lfsr
    import speech256_pkg::*;
(
    input  logic              clk,
    input  logic              rst_an,
    input  logic              en,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (en) begin
            state_d = lfsr_step(state_q);
        end
    end

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            state_q <= seed;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/speech_source.sv
// Speech256 excitation source: pulse train when voiced, LFSR noise when
// unvoiced, one registered sample per sample tick plus a period_done pulse.
module speech_source
    import speech256_pkg::*;
#(
    parameter int                NOISE_PERIOD = NOISE_PERIOD_DEF,
    parameter logic [LFSR_W-1:0] LFSR_SEED    = LFSR_SEED_DEF
) (
    input  logic                       clk,
    input  logic                       rst_an,
    input  logic                       sample_stb,
    input  logic [PERIOD_W-1:0]        period_in,
    input  logic [SAMPLE_W-1:0]        amp_in,
    output logic signed [SAMPLE_W-1:0] source_out,
    output logic                       source_stb,
    output logic                       period_done
);

    localparam logic [PERIOD_W-1:0] NOISE_RELOAD = PERIOD_W'(NOISE_PERIOD - 1);

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                noise_mode_q, noise_mode_d;
    logic [SAMPLE_W-1:0] source_out_q, source_out_d;
    logic                source_stb_q, source_stb_d;
    logic                period_done_q, period_done_d;

    logic                lfsr_en;
    logic [LFSR_W-1:0]   lfsr_state;

    logic                wrap;
    logic                period_is_noise;
    logic                mode_eff;
    logic [SAMPLE_W-1:0] mag;

    speech_lfsr u_lfsr (
        .clk    (clk),
        .rst_an (rst_an),
        .en     (lfsr_en),
        .seed   (LFSR_SEED),
        .state  (lfsr_state)
    );

    // A wrap tick switches to the new mode before the sample is produced.
    always_comb begin
        wrap            = (cnt_q == '0);
        period_is_noise = (period_in == '0);
        mode_eff        = wrap ? period_is_noise : noise_mode_q;
        mag             = amp_to_mag(amp_in);
    end

    always_comb begin
        cnt_d         = cnt_q;
        noise_mode_d  = noise_mode_q;
        source_out_d  = source_out_q;
        source_stb_d  = 1'b0;
        period_done_d = 1'b0;
        lfsr_en       = 1'b0;

        if (sample_stb) begin
            source_stb_d = 1'b1;

            if (wrap) begin
                period_done_d = 1'b1;
                noise_mode_d  = period_is_noise;
                cnt_d         = period_is_noise ? NOISE_RELOAD : period_in - 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end

            // Noise consumes the pre-shift LSB and then advances the LFSR.
            if (mode_eff) begin
                lfsr_en      = 1'b1;
                source_out_d = lfsr_state[0] ? mag : -mag;
            end else begin
                source_out_d = wrap ? mag : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            cnt_q         <= '0;
            noise_mode_q  <= 1'b0;
            source_out_q  <= '0;
            source_stb_q  <= 1'b0;
            period_done_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            noise_mode_q  <= noise_mode_d;
            source_out_q  <= source_out_d;
            source_stb_q  <= source_stb_d;
            period_done_q <= period_done_d;
        end
    end

    assign source_out  = source_out_q;
    assign source_stb  = source_stb_q;
    assign period_done = period_done_q;

endmodule
